// File: rtl/sys_array.sv
// 3x3 weight-stationary int8 systolic MAC array with 32-bit partial sums.
// Define SYSARRAY_INTER_EN to add the per-column cascade weight*activation term.
module sys_array (
  input  logic        clk,
  input  logic        rst,
  input  logic        weight_in_vec_vld_0,
  input  logic [7:0]  weight_in_vec_data_0,
  output logic        weight_in_vec_busy_0,
  input  logic        weight_in_vec_vld_1,
  input  logic [7:0]  weight_in_vec_data_1,
  output logic        weight_in_vec_busy_1,
  input  logic        weight_in_vec_vld_2,
  input  logic [7:0]  weight_in_vec_data_2,
  output logic        weight_in_vec_busy_2,
  input  logic        act_in_vec_vld_0,
  input  logic [7:0]  act_in_vec_data_0,
  output logic        act_in_vec_busy_0,
  input  logic        act_in_vec_vld_1,
  input  logic [7:0]  act_in_vec_data_1,
  output logic        act_in_vec_busy_1,
  input  logic        act_in_vec_vld_2,
  input  logic [7:0]  act_in_vec_data_2,
  output logic        act_in_vec_busy_2,
  input  logic        accum_in_vec_vld_0,
  input  logic [31:0] accum_in_vec_data_0,
  output logic        accum_in_vec_busy_0,
  input  logic        accum_in_vec_vld_1,
  input  logic [31:0] accum_in_vec_data_1,
  output logic        accum_in_vec_busy_1,
  input  logic        accum_in_vec_vld_2,
  input  logic [31:0] accum_in_vec_data_2,
  output logic        accum_in_vec_busy_2,
  output logic        accum_out_vec_vld_0,
  output logic [31:0] accum_out_vec_data_0,
  input  logic        accum_out_vec_busy_0,
  output logic        accum_out_vec_vld_1,
  output logic [31:0] accum_out_vec_data_1,
  input  logic        accum_out_vec_busy_1,
  output logic        accum_out_vec_vld_2,
  output logic [31:0] accum_out_vec_data_2,
  input  logic        accum_out_vec_busy_2,
  input  logic        weight_inter_vld_0,
  input  logic [7:0]  weight_inter_data_0,
  output logic        weight_inter_busy_0,
  input  logic        weight_inter_vld_1,
  input  logic [7:0]  weight_inter_data_1,
  output logic        weight_inter_busy_1,
  input  logic        weight_inter_vld_2,
  input  logic [7:0]  weight_inter_data_2,
  output logic        weight_inter_busy_2,
  input  logic        act_inter_vld_0,
  input  logic [7:0]  act_inter_data_0,
  output logic        act_inter_busy_0,
  input  logic        act_inter_vld_1,
  input  logic [7:0]  act_inter_data_1,
  output logic        act_inter_busy_1,
  input  logic        act_inter_vld_2,
  input  logic [7:0]  act_inter_data_2,
  output logic        act_inter_busy_2
);

  logic              w_vld [3];
  logic signed [7:0] w_data [3];
  logic              w_take [3];
  logic              act_vld [3];
  logic signed [7:0] act_data [3];
  logic              acc_vld [3];
  logic [31:0]       acc_data [3];
  logic              out_busy [3];
  logic              out_vld [3];
  logic [31:0]       out_data [3];

  // w[row][col]; row0 holds the most recent beat of a column
  logic signed [7:0] w [3][3];
  logic [1:0]        cnt [3];
  logic              any_out;
  logic              fire;
  logic signed [15:0] prod;
  logic [31:0]       sum [3];

  assign w_vld    = '{weight_in_vec_vld_0, weight_in_vec_vld_1, weight_in_vec_vld_2};
  assign w_data   = '{weight_in_vec_data_0, weight_in_vec_data_1, weight_in_vec_data_2};
  assign act_vld  = '{act_in_vec_vld_0, act_in_vec_vld_1, act_in_vec_vld_2};
  assign act_data = '{act_in_vec_data_0, act_in_vec_data_1, act_in_vec_data_2};
  assign acc_vld  = '{accum_in_vec_vld_0, accum_in_vec_vld_1, accum_in_vec_vld_2};
  assign acc_data = '{accum_in_vec_data_0, accum_in_vec_data_1, accum_in_vec_data_2};
  assign out_busy = '{accum_out_vec_busy_0, accum_out_vec_busy_1, accum_out_vec_busy_2};

  assign any_out = out_vld[0] | out_vld[1] | out_vld[2];

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_take[k] = w_vld[k] & ~((cnt[k] == 2'd3) & any_out);
    end
  end

  // A lane blocks the next beat only while it holds a result nobody is taking
  always_comb begin
    fire = 1'b1;
    for (int j = 0; j < 3; j++) begin
      if (cnt[j] != 2'd3) fire = 1'b0;
      if (!act_vld[j] || !acc_vld[j]) fire = 1'b0;
      if (out_vld[j] && out_busy[j]) fire = 1'b0;
    end
`ifdef SYSARRAY_INTER_EN
    if (!(weight_inter_vld_0 && weight_inter_vld_1 && weight_inter_vld_2 &&
          act_inter_vld_0 && act_inter_vld_1 && act_inter_vld_2)) fire = 1'b0;
`endif
  end

  always_comb begin
    prod = '0;
    for (int j = 0; j < 3; j++) begin
      sum[j] = acc_data[j];
      for (int i = 0; i < 3; i++) begin
        prod   = w[i][j] * act_data[i];
        sum[j] = sum[j] + {{16{prod[15]}}, prod};
      end
    end
`ifdef SYSARRAY_INTER_EN
    prod   = $signed(weight_inter_data_0) * $signed(act_inter_data_0);
    sum[0] = sum[0] + {{16{prod[15]}}, prod};
    prod   = $signed(weight_inter_data_1) * $signed(act_inter_data_1);
    sum[1] = sum[1] + {{16{prod[15]}}, prod};
    prod   = $signed(weight_inter_data_2) * $signed(act_inter_data_2);
    sum[2] = sum[2] + {{16{prod[15]}}, prod};
`endif
  end

  // Reloading a full column restarts its count at 1 with the new beat in row0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        cnt[k] <= 2'd0;
        for (int r = 0; r < 3; r++) w[r][k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (w_take[k]) begin
          w[2][k] <= w[1][k];
          w[1][k] <= w[0][k];
          w[0][k] <= w_data[k];
          cnt[k]  <= (cnt[k] == 2'd3) ? 2'd1 : cnt[k] + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < 3; j++) begin
        out_vld[j]  <= 1'b0;
        out_data[j] <= '0;
      end
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (fire) begin
          out_vld[j]  <= 1'b1;
          out_data[j] <= sum[j];
        end else if (out_vld[j] && !out_busy[j]) begin
          out_vld[j] <= 1'b0;
        end
      end
    end
  end

  assign weight_in_vec_busy_0 = ~w_take[0] & w_vld[0] | ((cnt[0] == 2'd3) & any_out);
  assign weight_in_vec_busy_1 = ~w_take[1] & w_vld[1] | ((cnt[1] == 2'd3) & any_out);
  assign weight_in_vec_busy_2 = ~w_take[2] & w_vld[2] | ((cnt[2] == 2'd3) & any_out);

  assign act_in_vec_busy_0   = ~fire;
  assign act_in_vec_busy_1   = ~fire;
  assign act_in_vec_busy_2   = ~fire;
  assign accum_in_vec_busy_0 = ~fire;
  assign accum_in_vec_busy_1 = ~fire;
  assign accum_in_vec_busy_2 = ~fire;

  assign accum_out_vec_vld_0  = out_vld[0];
  assign accum_out_vec_vld_1  = out_vld[1];
  assign accum_out_vec_vld_2  = out_vld[2];
  assign accum_out_vec_data_0 = out_data[0];
  assign accum_out_vec_data_1 = out_data[1];
  assign accum_out_vec_data_2 = out_data[2];

`ifdef SYSARRAY_INTER_EN
  assign weight_inter_busy_0 = ~fire;
  assign weight_inter_busy_1 = ~fire;
  assign weight_inter_busy_2 = ~fire;
  assign act_inter_busy_0    = ~fire;
  assign act_inter_busy_1    = ~fire;
  assign act_inter_busy_2    = ~fire;
`else
  // Cascade beats are swallowed without touching the datapath
  logic unused_inter;
  assign unused_inter = ^{weight_inter_vld_0, weight_inter_vld_1, weight_inter_vld_2,
                          weight_inter_data_0, weight_inter_data_1, weight_inter_data_2,
                          act_inter_vld_0, act_inter_vld_1, act_inter_vld_2,
                          act_inter_data_0, act_inter_data_1, act_inter_data_2};
  assign weight_inter_busy_0 = 1'b0;
  assign weight_inter_busy_1 = 1'b0;
  assign weight_inter_busy_2 = 1'b0;
  assign act_inter_busy_0    = 1'b0;
  assign act_inter_busy_1    = 1'b0;
  assign act_inter_busy_2    = 1'b0;
`endif

endmodule

// File: tb/tb_sys_array.sv
// Bench for sys_array: directed cases plus random traffic against a beat-level model.
// The model tracks each column as its list of accepted weight beats.
module tb_sys_array;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        w_vld [3];
  logic [7:0]  w_dat [3];
  logic        w_busy [3];
  logic        a_vld [3];
  logic [7:0]  a_dat [3];
  logic        a_busy [3];
  logic        c_vld [3];
  logic [31:0] c_dat [3];
  logic        c_busy [3];
  logic        o_vld [3];
  logic [31:0] o_dat [3];
  logic        o_busy [3];
  logic        wi_vld [3];
  logic [7:0]  wi_dat [3];
  logic        wi_busy [3];
  logic        ai_vld [3];
  logic [7:0]  ai_dat [3];
  logic        ai_busy [3];

  int checks = 0;
  int errors = 0;

  // Model: most recent beat first, so wq[col][row] is the weight at that row
  int          wq [3][$];
  int          mcnt [3];
  logic        m_vld [3];
  logic [31:0] m_dat [3];

  sys_array dut (
    .clk(clk), .rst(rst),
    .weight_in_vec_vld_0(w_vld[0]), .weight_in_vec_data_0(w_dat[0]), .weight_in_vec_busy_0(w_busy[0]),
    .weight_in_vec_vld_1(w_vld[1]), .weight_in_vec_data_1(w_dat[1]), .weight_in_vec_busy_1(w_busy[1]),
    .weight_in_vec_vld_2(w_vld[2]), .weight_in_vec_data_2(w_dat[2]), .weight_in_vec_busy_2(w_busy[2]),
    .act_in_vec_vld_0(a_vld[0]), .act_in_vec_data_0(a_dat[0]), .act_in_vec_busy_0(a_busy[0]),
    .act_in_vec_vld_1(a_vld[1]), .act_in_vec_data_1(a_dat[1]), .act_in_vec_busy_1(a_busy[1]),
    .act_in_vec_vld_2(a_vld[2]), .act_in_vec_data_2(a_dat[2]), .act_in_vec_busy_2(a_busy[2]),
    .accum_in_vec_vld_0(c_vld[0]), .accum_in_vec_data_0(c_dat[0]), .accum_in_vec_busy_0(c_busy[0]),
    .accum_in_vec_vld_1(c_vld[1]), .accum_in_vec_data_1(c_dat[1]), .accum_in_vec_busy_1(c_busy[1]),
    .accum_in_vec_vld_2(c_vld[2]), .accum_in_vec_data_2(c_dat[2]), .accum_in_vec_busy_2(c_busy[2]),
    .accum_out_vec_vld_0(o_vld[0]), .accum_out_vec_data_0(o_dat[0]), .accum_out_vec_busy_0(o_busy[0]),
    .accum_out_vec_vld_1(o_vld[1]), .accum_out_vec_data_1(o_dat[1]), .accum_out_vec_busy_1(o_busy[1]),
    .accum_out_vec_vld_2(o_vld[2]), .accum_out_vec_data_2(o_dat[2]), .accum_out_vec_busy_2(o_busy[2]),
    .weight_inter_vld_0(wi_vld[0]), .weight_inter_data_0(wi_dat[0]), .weight_inter_busy_0(wi_busy[0]),
    .weight_inter_vld_1(wi_vld[1]), .weight_inter_data_1(wi_dat[1]), .weight_inter_busy_1(wi_busy[1]),
    .weight_inter_vld_2(wi_vld[2]), .weight_inter_data_2(wi_dat[2]), .weight_inter_busy_2(wi_busy[2]),
    .act_inter_vld_0(ai_vld[0]), .act_inter_data_0(ai_dat[0]), .act_inter_busy_0(ai_busy[0]),
    .act_inter_vld_1(ai_vld[1]), .act_inter_data_1(ai_dat[1]), .act_inter_busy_1(ai_busy[1]),
    .act_inter_vld_2(ai_vld[2]), .act_inter_data_2(ai_dat[2]), .act_inter_busy_2(ai_busy[2])
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      wq[k]    = '{0, 0, 0};
      mcnt[k]  = 0;
      m_vld[k] = 1'b0;
      m_dat[k] = '0;
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      w_vld[k] = 1'b0; w_dat[k] = '0;
      a_vld[k] = 1'b0; a_dat[k] = '0;
      c_vld[k] = 1'b0; c_dat[k] = '0;
      o_busy[k] = 1'b0;
      wi_vld[k] = 1'b0; wi_dat[k] = '0;
      ai_vld[k] = 1'b0; ai_dat[k] = '0;
    end
  endtask

  task automatic apply_stimulus(input logic v, input int a0, input int a1, input int a2,
                                input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2);
    for (int k = 0; k < 3; k++) begin
      a_vld[k] = v;
      c_vld[k] = v;
    end
    a_dat[0] = 8'(a0); a_dat[1] = 8'(a1); a_dat[2] = 8'(a2);
    c_dat[0] = c0;     c_dat[1] = c1;     c_dat[2] = c2;
  endtask

  // Called just after a falling edge with inputs already driven; checks busy,
  // advances the model over the next rising edge, then checks the lanes.
  task automatic cycle();
    logic        any_out, fire, wfull;
    logic [31:0] res [3];
    #1;
    any_out = m_vld[0] | m_vld[1] | m_vld[2];
    fire = 1'b1;
    for (int j = 0; j < 3; j++) begin
      if (mcnt[j] != 3 || !a_vld[j] || !c_vld[j]) fire = 1'b0;
      if (m_vld[j] && o_busy[j]) fire = 1'b0;
`ifdef SYSARRAY_INTER_EN
      if (!wi_vld[j] || !ai_vld[j]) fire = 1'b0;
`endif
    end
    for (int j = 0; j < 3; j++) begin
      wfull = (mcnt[j] == 3) && any_out;
      check_output($sformatf("w_busy%0d", j), 32'(w_busy[j]), 32'(wfull));
      check_output($sformatf("a_busy%0d", j), 32'(a_busy[j]), 32'(!fire));
      check_output($sformatf("c_busy%0d", j), 32'(c_busy[j]), 32'(!fire));
`ifdef SYSARRAY_INTER_EN
      check_output($sformatf("wi_busy%0d", j), 32'(wi_busy[j]), 32'(!fire));
      check_output($sformatf("ai_busy%0d", j), 32'(ai_busy[j]), 32'(!fire));
`else
      check_output($sformatf("wi_busy%0d", j), 32'(wi_busy[j]), 32'd0);
      check_output($sformatf("ai_busy%0d", j), 32'(ai_busy[j]), 32'd0);
`endif
      res[j] = c_dat[j];
      for (int i = 0; i < 3; i++) res[j] = res[j] + 32'(wq[j][i] * int'($signed(a_dat[i])));
`ifdef SYSARRAY_INTER_EN
      res[j] = res[j] + 32'(int'($signed(wi_dat[j])) * int'($signed(ai_dat[j])));
`endif
    end
    @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      if (w_vld[j] && !((mcnt[j] == 3) && any_out)) begin
        wq[j].push_front(int'($signed(w_dat[j])));
        void'(wq[j].pop_back());
        mcnt[j] = (mcnt[j] == 3) ? 1 : mcnt[j] + 1;
      end
      if (fire) begin
        m_vld[j] = 1'b1;
        m_dat[j] = res[j];
      end else if (m_vld[j] && !o_busy[j]) begin
        m_vld[j] = 1'b0;
      end
    end
    #1;
    for (int j = 0; j < 3; j++) begin
      check_output($sformatf("o_vld%0d", j), 32'(o_vld[j]), 32'(m_vld[j]));
      if (m_vld[j]) check_output($sformatf("o_dat%0d", j), o_dat[j], m_dat[j]);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Column 0 gets beats b0,b1,b2; columns 1 and 2 get 'other' three times
  task automatic load_weights(input int b0, input int b1, input int b2, input int other);
    int beats [3];
    beats = '{b0, b1, b2};
    step(); apply_stimulus(1'b0, 0, 0, 0, 0, 0, 0); cycle();
    for (int n = 0; n < 3; n++) begin
      step();
      for (int k = 0; k < 3; k++) w_vld[k] = 1'b1;
      w_dat[0] = 8'(beats[n]);
      w_dat[1] = 8'(other);
      w_dat[2] = 8'(other);
      cycle();
    end
    step();
    for (int k = 0; k < 3; k++) w_vld[k] = 1'b0;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst = 1'b0;
    #12;
    for (int j = 0; j < 3; j++) begin
      check_output("rst_o_vld", 32'(o_vld[j]), 32'd0);
      check_output("rst_w_busy", 32'(w_busy[j]), 32'd0);
      check_output("rst_a_busy", 32'(a_busy[j]), 32'd1);
      check_output("rst_c_busy", 32'(c_busy[j]), 32'd1);
    end
    step(); rst = 1'b1;
    cycle();

    // All-ones weights
    load_weights(1, 1, 1, 1);
    apply_stimulus(1'b1, 1, 2, 3, 10, 20, 30);
    cycle();
    check_output("ones_out0", o_dat[0], 32'd16);
    check_output("ones_out1", o_dat[1], 32'd26);
    check_output("ones_out2", o_dat[2], 32'd36);

    // Row order in column 0
    load_weights(5, 6, 7, 0);
    apply_stimulus(1'b1, 1, 0, 0, 0, 0, 0);
    cycle();
    check_output("row0_out0", o_dat[0], 32'd7);
    step(); apply_stimulus(1'b1, 0, 0, 1, 0, 0, 0);
    cycle();
    check_output("row2_out0", o_dat[0], 32'd5);

    // Most negative operands
    load_weights(-128, -128, -128, -128);
    apply_stimulus(1'b1, -128, -128, -128, 0, 0, 0);
    cycle();
    check_output("neg_out1", o_dat[1], 32'd49152);

    // Accumulator wrap
    load_weights(1, 1, 1, 1);
    apply_stimulus(1'b1, 1, 0, 0, 32'h7FFF_FFFF, 0, 0);
    cycle();
    check_output("wrap_out0", o_dat[0], 32'h8000_0000);

    // Stall lane 1 for three cycles while inputs stay valid
    step(); apply_stimulus(1'b1, 2, 3, 4, 100, 200, 300);
    cycle();
    for (int n = 0; n < 3; n++) begin
      step(); apply_stimulus(1'b1, 7, 7, 7, 1, 1, 1); o_busy[1] = 1'b1;
      cycle();
      check_output("stall_hold1", o_dat[1], 32'd209);
    end
    step(); o_busy[1] = 1'b0;
    cycle();

    // Random traffic with random weight reloads and downstream stalls
    for (int n = 0; n < 400; n++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        w_vld[k]  = ($urandom_range(0, 9) == 0);
        w_dat[k]  = 8'($urandom);
        a_vld[k]  = ($urandom_range(0, 9) != 0);
        a_dat[k]  = 8'($urandom);
        c_vld[k]  = ($urandom_range(0, 9) != 0);
        c_dat[k]  = $urandom;
        o_busy[k] = ($urandom_range(0, 3) == 0);
        wi_vld[k] = ($urandom_range(0, 7) != 0);
        wi_dat[k] = 8'($urandom);
        ai_vld[k] = ($urandom_range(0, 7) != 0);
        ai_dat[k] = 8'($urandom);
      end
      cycle();
    end

    // Reset in the middle of streaming
    load_weights(2, 2, 2, 2);
    apply_stimulus(1'b1, 1, 1, 1, 0, 0, 0);
    cycle();
    step(); #2; rst = 1'b0; #1;
    model_reset();
    for (int j = 0; j < 3; j++) begin
      check_output("mid_rst_o_vld", 32'(o_vld[j]), 32'd0);
      check_output("mid_rst_o_dat", o_dat[j], 32'd0);
      check_output("mid_rst_a_busy", 32'(a_busy[j]), 32'd1);
      check_output("mid_rst_w_busy", 32'(w_busy[j]), 32'd0);
    end
    step(); rst = 1'b1;
    cycle();
    step(); cycle();
    load_weights(0, 0, 0, 0);

    // Cascade term
    for (int k = 0; k < 3; k++) begin
      wi_vld[k] = 1'b1; wi_dat[k] = 8'd3;
      ai_vld[k] = 1'b1; ai_dat[k] = 8'd4;
    end
    apply_stimulus(1'b1, 9, 9, 9, 1, 1, 1);
    cycle();
`ifdef SYSARRAY_INTER_EN
    check_output("inter_out2", o_dat[2], 32'd13);
`else
    check_output("inter_out2", o_dat[2], 32'd1);
`endif
    step(); clear_inputs();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
